// File: rtl/sw_debounce_if.sv
// Switch conditioner bus: raw pins in, debounced level, edge strobes and change count out.
interface sw_debounce_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] sw;
    logic [WIDTH-1:0] sw_stable;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             changed;
    logic [CNT_W-1:0] change_count;

    modport master (
        output sw,
        input  sw_stable, sw_rise, sw_fall, changed, change_count
    );

    modport slave (
        input  sw,
        output sw_stable, sw_rise, sw_fall, changed, change_count
    );
endinterface

// File: rtl/sw_debounce.sv
// DIP switch conditioner: per-bit synchroniser, stability-counter debounce FSM,
// registered rise/fall/changed strobes and a wrapping change counter.
module sw_debounce #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_W           = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    sw_debounce_if.slave   io_bus
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CAND   = 1'b1
    } state_t;

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] w_sw_sync;

    state_t           r_state     [WIDTH];
    state_t           w_state_nxt [WIDTH];
    logic [CW-1:0]    r_cnt       [WIDTH];
    logic [CW-1:0]    w_cnt_nxt   [WIDTH];

    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] w_stable_nxt;
    logic [WIDTH-1:0] w_accept;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] w_rise_nxt;
    logic [WIDTH-1:0] r_fall;
    logic [WIDTH-1:0] w_fall_nxt;
    logic             r_changed;
    logic             w_changed_nxt;
    logic [CNT_W-1:0] r_count;

    // Raw pins touch only r_sync[0]; everything downstream sees the last stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
        end else begin
            r_sync[0] <= io_bus.sw;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
    end

    assign w_sw_sync = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_stable_nxt = r_stable;
        w_accept     = '0;
        w_rise_nxt   = '0;
        w_fall_nxt   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            case (r_state[i])
                ST_STABLE: begin
                    if (w_sw_sync[i] == r_stable[i]) begin
                        w_cnt_nxt[i] = '0;
                    end else if (DEBOUNCE_CYCLES == 1) begin
                        w_accept[i] = 1'b1;
                    end else begin
                        w_cnt_nxt[i]   = CW'(1);
                        w_state_nxt[i] = ST_CAND;
                    end
                end
                ST_CAND: begin
                    if (w_sw_sync[i] == r_stable[i]) begin
                        w_cnt_nxt[i]   = '0;
                        w_state_nxt[i] = ST_STABLE;
                    end else if (r_cnt[i] == CNT_LAST) begin
                        w_accept[i] = 1'b1;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + CW'(1);
                    end
                end
                default: begin
                    w_cnt_nxt[i]   = '0;
                    w_state_nxt[i] = ST_STABLE;
                end
            endcase
            // Acceptance commits the new level and strobes its direction on the same edge.
            if (w_accept[i]) begin
                w_stable_nxt[i] = w_sw_sync[i];
                w_rise_nxt[i]   = w_sw_sync[i];
                w_fall_nxt[i]   = ~w_sw_sync[i];
                w_cnt_nxt[i]    = '0;
                w_state_nxt[i]  = ST_STABLE;
            end
        end
        w_changed_nxt = |(w_rise_nxt | w_fall_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_state[i] <= ST_STABLE;
                r_cnt[i]   <= '0;
            end
            r_stable  <= '0;
            r_rise    <= '0;
            r_fall    <= '0;
            r_changed <= 1'b0;
            r_count   <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
            r_stable  <= w_stable_nxt;
            r_rise    <= w_rise_nxt;
            r_fall    <= w_fall_nxt;
            r_changed <= w_changed_nxt;
            if (w_changed_nxt) r_count <= r_count + CNT_W'(1);
        end
    end

    assign io_bus.sw_stable    = r_stable;
    assign io_bus.sw_rise      = r_rise;
    assign io_bus.sw_fall      = r_fall;
    assign io_bus.changed      = r_changed;
    assign io_bus.change_count = r_count;
endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: directed scenarios plus random switch activity against a
// window-based reference model (a level is accepted once D consecutive synced samples differ).
module tb_sw_debounce;
    localparam int WIDTH = 4;
    localparam int SYNC  = 2;
    localparam int DEB   = 8;
    localparam int CNT_W = 8;

    logic clk;
    logic rst_n;

    sw_debounce_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    sw_debounce #(
        .WIDTH(WIDTH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_W(CNT_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] m_stable, m_rise, m_fall;
    logic             m_changed;
    logic [CNT_W-1:0] m_count;
    logic [WIDTH-1:0] hist[$];

    function automatic void model_clear();
        m_stable  = '0;
        m_rise    = '0;
        m_fall    = '0;
        m_changed = 1'b0;
        m_count   = '0;
        hist.delete();
    endfunction

    // Edge k looks at the pin sample taken SYNC edges earlier; a bit flips when the
    // DEB most recent such samples all disagree with the current stable level.
    function automatic void model_step(input logic [WIDTH-1:0] pins);
        logic [WIDTH-1:0] s;
        logic             all_diff;
        int               idx;
        hist.push_back(pins);
        m_rise = '0;
        m_fall = '0;
        for (int b = 0; b < WIDTH; b++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DEB; j++) begin
                idx = hist.size() - 1 - SYNC - j;
                s = (idx >= 0) ? hist[idx] : '0;
                if (s[b] == m_stable[b]) all_diff = 1'b0;
            end
            if (all_diff) begin
                if (m_stable[b]) m_fall[b] = 1'b1;
                else             m_rise[b] = 1'b1;
                m_stable[b] = ~m_stable[b];
            end
        end
        m_changed = |(m_rise | m_fall);
        if (m_changed) m_count = m_count + 1'b1;
        if (hist.size() > 32) void'(hist.pop_front());
    endfunction

    function automatic logic [20:0] dut_vec();
        return {bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.changed, bus.change_count};
    endfunction

    function automatic logic [20:0] mdl_vec();
        return {m_stable, m_rise, m_fall, m_changed, m_count};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_clear();
        else        model_step(bus.sw);
        @(negedge clk);
    endtask

    task automatic apply_reset(input logic [WIDTH-1:0] v);
        @(negedge clk);
        rst_n  = 1'b0;
        bus.sw = v;
        model_clear();
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        bus.sw = 4'b1111;
        rst_n  = 1'b0;
        model_clear();
        #1;
        checks++;
        if (dut_vec() !== 21'h0) begin
            errors++;
            $display("FAIL reset_zero: got %h expected %h", dut_vec(), 21'h0);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL reset_release_model: edge %0d got %h expected %h", k, dut_vec(), mdl_vec());
            end
            if (k == 9) begin
                checks++;
                if (bus.sw_stable !== 4'b0000) begin
                    errors++;
                    $display("FAIL reset_early: got %b expected 0000", bus.sw_stable);
                end
            end
        end
        checks++;
        if ({bus.sw_stable, bus.sw_rise, bus.changed, bus.change_count} !== {4'hF, 4'hF, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL reset_accept: got %b %b %b %0d expected 1111 1111 1 1",
                     bus.sw_stable, bus.sw_rise, bus.changed, bus.change_count);
        end
        tick();
        checks++;
        if ({bus.sw_rise, bus.changed, bus.change_count} !== {4'h0, 1'b0, 8'd1}) begin
            errors++;
            $display("FAIL reset_pulse_end: got %b %b %0d expected 0000 0 1",
                     bus.sw_rise, bus.changed, bus.change_count);
        end
    endtask

    task automatic test_step();
        apply_reset(4'h0);
        for (int v = 1; v < 16; v++) begin
            bus.sw = 4'(v);
            for (int k = 1; k <= 10; k++) begin
                tick();
                checks++;
                if (dut_vec() !== mdl_vec()) begin
                    errors++;
                    $display("FAIL step_model: v=%0d edge %0d got %h expected %h", v, k, dut_vec(), mdl_vec());
                end
            end
            checks++;
            if (bus.sw_stable !== 4'(v)) begin
                errors++;
                $display("FAIL step_level: got %h expected %h", bus.sw_stable, 4'(v));
            end
        end
        checks++;
        if (bus.change_count !== 8'd15) begin
            errors++;
            $display("FAIL step_count: got %0d expected 15", bus.change_count);
        end
    endtask

    task automatic test_glitch();
        apply_reset(4'h0);
        bus.sw = 4'b0100;
        repeat (5) tick();
        bus.sw = 4'b0000;
        for (int k = 0; k < 15; k++) begin
            tick();
            checks++;
            if (dut_vec() !== 21'h0) begin
                errors++;
                $display("FAIL glitch: got %h expected %h", dut_vec(), 21'h0);
            end
        end
    endtask

    task automatic test_simultaneous();
        apply_reset(4'b0101);
        repeat (10) tick();
        checks++;
        if ({bus.sw_stable, bus.change_count} !== {4'b0101, 8'd1}) begin
            errors++;
            $display("FAIL simul_setup: got %b %0d expected 0101 1", bus.sw_stable, bus.change_count);
        end
        bus.sw = 4'b1010;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL simul_model: edge %0d got %h expected %h", k, dut_vec(), mdl_vec());
            end
        end
        checks++;
        if ({bus.sw_rise, bus.sw_fall, bus.changed, bus.change_count} !== {4'b1010, 4'b0101, 1'b1, 8'd2}) begin
            errors++;
            $display("FAIL simul_pulses: got %b %b %b %0d expected 1010 0101 1 2",
                     bus.sw_rise, bus.sw_fall, bus.changed, bus.change_count);
        end
        tick();
        checks++;
        if ({bus.changed, bus.change_count} !== {1'b0, 8'd2}) begin
            errors++;
            $display("FAIL simul_once: got %b %0d expected 0 2", bus.changed, bus.change_count);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset(4'h0);
        bus.sw = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (dut_vec() !== 21'h0) begin
                errors++;
                $display("FAIL mid_no_pulse: got %h expected %h", dut_vec(), 21'h0);
            end
        end
        rst_n = 1'b0;
        model_clear();
        #1;
        checks++;
        if (dut_vec() !== 21'h0) begin
            errors++;
            $display("FAIL mid_reset_zero: got %h expected %h", dut_vec(), 21'h0);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL mid_model: edge %0d got %h expected %h", k, dut_vec(), mdl_vec());
            end
            if (k == 9) begin
                checks++;
                if (bus.sw_stable !== 4'b0000) begin
                    errors++;
                    $display("FAIL mid_early: got %b expected 0000", bus.sw_stable);
                end
            end
        end
        checks++;
        if ({bus.sw_stable, bus.sw_rise} !== {4'b0001, 4'b0001}) begin
            errors++;
            $display("FAIL mid_accept: got %b %b expected 0001 0001", bus.sw_stable, bus.sw_rise);
        end
    endtask

    task automatic test_wrap();
        apply_reset(4'h0);
        for (int n = 0; n < 256; n++) begin
            bus.sw[0] = ~bus.sw[0];
            for (int k = 0; k < 10; k++) begin
                tick();
                checks++;
                if (dut_vec() !== mdl_vec()) begin
                    errors++;
                    $display("FAIL wrap_model: change %0d got %h expected %h", n, dut_vec(), mdl_vec());
                end
            end
        end
        checks++;
        if (bus.change_count !== 8'd0) begin
            errors++;
            $display("FAIL wrap_zero: got %0d expected 0", bus.change_count);
        end
        bus.sw[0] = ~bus.sw[0];
        repeat (10) tick();
        checks++;
        if (bus.change_count !== 8'd1) begin
            errors++;
            $display("FAIL wrap_next: got %0d expected 1", bus.change_count);
        end
    endtask

    task automatic test_random();
        int hold;
        apply_reset(4'($urandom));
        for (int seg = 0; seg < 300; seg++) begin
            if (seg % 3 == 0) bus.sw = 4'($urandom);
            else              bus.sw[$urandom_range(0, WIDTH-1)] = ~bus.sw[$urandom_range(0, WIDTH-1)];
            hold = $urandom_range(1, 14);
            for (int k = 0; k < hold; k++) begin
                tick();
                checks++;
                if (dut_vec() !== mdl_vec()) begin
                    errors++;
                    $display("FAIL random_model: seg %0d got %h expected %h", seg, dut_vec(), mdl_vec());
                end
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        bus.sw = '0;
        model_clear();
        test_reset();
        test_step();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1);
    end
endmodule
